keypad_scan: RTL and testbench

Multiplexed 4x4 keypad scanner for the kitchen timer's input side. It is the counterpart of the time-multiplexed seven-segment display driver: instead of strobing anodes and driving digit data, it strobes keypad columns one at a time, reads the row lines, and reduces each full sweep to a single key result. It debounces key presses and releases across whole sweeps. Each new press is reported as a 4-bit key code with a one-cycle valid pulse, which the digit-entry logic consumes to load `bin0`..`bin3`.

---
 rtl/kt_pkg.sv | 30 +++
 rtl/keypad_scan_if.sv | 20 ++
 rtl/keypad_sweep.sv | 90 +++++++++
 rtl/keypad_scan.sv | 126 ++++++++++++
 tb/tb_keypad_scan.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kt_pkg.sv
// Shared kitchen-timer types and constants: keypad FSM states, sweep frame
// results and the active-low column strobe patterns.
package kt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM,
      HELD,
      RELEASE
   } kp_state_t;

   typedef enum logic [1:0] {
      NONE,
      KEY,
      MULTI
   } kp_frame_t;

   localparam logic [3:0] COL_STROBE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Rows are active-low, so a pressed key shows up as a 0 bit.
   function automatic logic [2:0] low_count(input logic [3:0] rows_n);
      logic [2:0] n;
      n = 3'd0;
      for (int r = 0; r < 4; r++) begin
         if (!rows_n[r]) n = n + 3'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key report bus from the keypad scanner to the digit-entry logic.
interface keypad_scan_if;

   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      input key_code,
      input key_valid,
      input key_held
   );

endinterface

// File: rtl/keypad_sweep.sv
// Column strobe generator and row reader: synchronizes the rows, walks the
// columns and reduces each four-column sweep to a single frame result.
module keypad_sweep
   import kt_pkg::*;
#(
   parameter int COL_DWELL = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       frame_done,
   output kp_frame_t  frame_result,
   output logic [3:0] frame_code
);

   localparam int DW = $clog2(COL_DWELL);

   logic [3:0]    row_s1_q, row_s1_d;
   logic [3:0]    row_s2_q, row_s2_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [4:0]    low_cnt_q, low_cnt_d;
   logic [3:0]    last_code_q, last_code_d;

   logic          sample;
   logic          col_has_key;
   logic [3:0]    col_code;
   logic [4:0]    total_cnt;
   logic [3:0]    total_code;

   always_comb begin
      row_s1_d    = row;
      row_s2_d    = row_s1_q;
      sample      = (dwell_q == DW'(COL_DWELL - 1));
      dwell_d     = sample ? '0 : dwell_q + 1'b1;
      col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;

      // The highest-numbered low row wins so the code is the last one seen.
      col_has_key = ~&row_s2_q;
      col_code    = last_code_q;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2_q[r]) col_code = {col_idx_q, 2'(r)};
      end

      total_cnt   = low_cnt_q + {2'b00, low_count(row_s2_q)};
      total_code  = col_has_key ? col_code : last_code_q;
      frame_done  = sample && (col_idx_q == 2'd3);

      if (total_cnt == 5'd0) begin
         frame_result = NONE;
      end else if (total_cnt == 5'd1) begin
         frame_result = KEY;
      end else begin
         frame_result = MULTI;
      end
      frame_code  = total_code;

      low_cnt_d   = low_cnt_q;
      last_code_d = last_code_q;
      if (frame_done) begin
         low_cnt_d   = '0;
         last_code_d = '0;
      end else if (sample) begin
         low_cnt_d   = total_cnt;
         last_code_d = total_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1_q    <= 4'b1111;
         row_s2_q    <= 4'b1111;
         dwell_q     <= '0;
         col_idx_q   <= 2'd0;
         low_cnt_q   <= '0;
         last_code_q <= '0;
      end else begin
         row_s1_q    <= row_s1_d;
         row_s2_q    <= row_s2_d;
         dwell_q     <= dwell_d;
         col_idx_q   <= col_idx_d;
         low_cnt_q   <= low_cnt_d;
         last_code_q <= last_code_d;
      end
   end

   assign col = COL_STROBE[col_idx_q];

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: debounces sweep results across whole frames and reports
// each new press once, with no rollover while a key is held.
module keypad_scan
   import kt_pkg::*;
#(
   parameter int COL_DWELL = 16,
   parameter int DEBOUNCE  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    row,
   output logic [3:0]    col,
   keypad_scan_if.master key_if
);

   localparam int CNT_W = ($clog2(DEBOUNCE + 1) > 3) ? $clog2(DEBOUNCE + 1) : 3;

   logic       frame_done;
   kp_frame_t  frame_result;
   logic [3:0] frame_code;

   kp_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0] cand_q, cand_d;
   logic [3:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       held_q, held_d;

   keypad_sweep #(
      .COL_DWELL (COL_DWELL)
   ) u_sweep (
      .clk          (clk),
      .rst_n        (rst_n),
      .row          (row),
      .col          (col),
      .frame_done   (frame_done),
      .frame_result (frame_result),
      .frame_code   (frame_code)
   );

   // A frame matching the candidate completes debounce when cnt already holds DEBOUNCE-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      code_d  = code_q;
      valid_d = 1'b0;
      held_d  = held_q;

      if (frame_done) begin
         case (state_q)
            IDLE: begin
               if (frame_result == KEY) begin
                  state_d = CONFIRM;
                  cand_d  = frame_code;
                  cnt_d   = CNT_W'(1);
               end
            end
            CONFIRM: begin
               if (frame_result == KEY) begin
                  if (frame_code != cand_q) begin
                     cand_d = frame_code;
                     cnt_d  = CNT_W'(1);
                  end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                     state_d = HELD;
                     cnt_d   = '0;
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            HELD: begin
               if (frame_result == NONE) begin
                  state_d = RELEASE;
                  cnt_d   = CNT_W'(1);
               end
            end
            RELEASE: begin
               if (frame_result != NONE) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  held_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end
   end

   assign key_if.key_code  = code_q;
   assign key_if.key_valid = valid_q;
   assign key_if.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a simulated key matrix driven frame by
// frame, checked against a frame-level press/release model.
module tb_keypad_scan;

   localparam int CD    = 4;
   localparam int DB    = 3;
   localparam int FRAME = 4 * CD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pressed = 16'h0000;
   logic [3:0]  row;
   logic [3:0]  col;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   // Reference state: consecutive-frame run lengths instead of named states.
   int          m_run;
   int          m_none_run;
   logic [3:0]  m_last;
   logic [3:0]  m_code;
   logic        m_held;

   keypad_scan_if kif ();

   keypad_scan #(
      .COL_DWELL (CD),
      .DEBOUNCE  (DB)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .row    (row),
      .col    (col),
      .key_if (kif)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its row low while its column is strobed.
   always_comb begin
      row = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
         end
      end
   end

   task automatic model_reset();
      m_run      = 0;
      m_none_run = 0;
      m_last     = 4'd0;
      m_code     = 4'd0;
      m_held     = 1'b0;
   endtask

   task automatic model_frame(input logic [15:0] keys, output bit pulse);
      int n;
      int k;
      n = $countones(keys);
      k = 0;
      for (int i = 0; i < 16; i++) if (keys[i]) k = i;
      pulse = 1'b0;
      if (!m_held) begin
         if (n == 1) begin
            if (m_run > 0 && 4'(k) == m_last) m_run++;
            else begin
               m_run  = 1;
               m_last = 4'(k);
            end
            if (m_run == DB) begin
               pulse      = 1'b1;
               m_held     = 1'b1;
               m_code     = m_last;
               m_run      = 0;
               m_none_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end else begin
         if (n == 0) begin
            m_none_run++;
            if (m_none_run == DB) begin
               m_held     = 1'b0;
               m_none_run = 0;
               m_run      = 0;
            end
         end else begin
            m_none_run = 0;
         end
      end
   endtask

   task automatic run_frame(input logic [15:0] keys, input string tag);
      bit         pulse;
      bit         exp_valid;
      logic [3:0] exp_col;
      pressed = keys;
      for (int c = 0; c < FRAME; c++) begin
         @(posedge clk);
         #1;
         exp_valid = 1'b0;
         if (c == FRAME - 1) begin
            model_frame(keys, pulse);
            exp_valid = pulse;
         end
         exp_col = ~(4'b0001 << (((c + 1) / CD) % 4));
         if (kif.key_valid) pulses++;
         checks += 4;
         if (col !== exp_col) begin
            failures++;
            $display("[TB] FAIL %s col cyc=%0d got=%b want=%b", tag, c, col, exp_col);
         end
         if (kif.key_valid !== exp_valid) begin
            failures++;
            $display("[TB] FAIL %s key_valid cyc=%0d got=%b want=%b", tag, c, kif.key_valid, exp_valid);
         end
         if (kif.key_held !== m_held) begin
            failures++;
            $display("[TB] FAIL %s key_held cyc=%0d got=%b want=%b", tag, c, kif.key_held, m_held);
         end
         if (kif.key_code !== m_code) begin
            failures++;
            $display("[TB] FAIL %s key_code cyc=%0d got=%0d want=%0d", tag, c, kif.key_code, m_code);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks += 4;
      if (col !== 4'b1110) begin
         failures++;
         $display("[TB] FAIL %s col got=%b want=1110", tag, col);
      end
      if (kif.key_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s key_valid got=%b want=0", tag, kif.key_valid);
      end
      if (kif.key_held !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s key_held got=%b want=0", tag, kif.key_held);
      end
      if (kif.key_code !== 4'd0) begin
         failures++;
         $display("[TB] FAIL %s key_code got=%0d want=0", tag, kif.key_code);
      end
   endtask

   task automatic check_pulses(input int want, input string tag);
      checks++;
      if (pulses !== want) begin
         failures++;
         $display("[TB] FAIL %s pulse_count got=%0d want=%0d", tag, pulses, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pressed = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_frame(16'h0000, "sweep0");
      run_frame(16'h0000, "sweep1");
   endtask

   task automatic test_clean_press();
      pulses = 0;
      repeat (3) run_frame(16'h0200, "clean_press");
      repeat (3) run_frame(16'h0000, "clean_release");
      check_pulses(1, "clean");
   endtask

   task automatic test_bounce();
      pulses = 0;
      repeat (2) run_frame(16'h0200, "bounce_pre");
      run_frame(16'h0000, "bounce_gap");
      repeat (3) run_frame(16'h0200, "bounce_press");
      run_frame(16'h0000, "bounce_glitch");
      repeat (2) run_frame(16'h0200, "bounce_hold");
      repeat (3) run_frame(16'h0000, "bounce_release");
      check_pulses(1, "bounce");
   endtask

   task automatic test_ghost_rollover();
      pulses = 0;
      repeat (5) run_frame(16'h0021, "ghost");
      check_pulses(0, "ghost");
      repeat (3) run_frame(16'h0001, "roll_k0");
      repeat (2) run_frame(16'h0021, "roll_k0k5");
      repeat (3) run_frame(16'h0020, "roll_k5");
      repeat (3) run_frame(16'h0000, "roll_release");
      check_pulses(1, "rollover");
   endtask

   task automatic test_reset_mid_debounce();
      pulses = 0;
      run_frame(16'h0200, "mid_first");
      pressed = 16'h0200;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) run_frame(16'h0200, "mid_recount");
      check_pulses(0, "mid_early");
      run_frame(16'h0200, "mid_accept");
      repeat (3) run_frame(16'h0000, "mid_release");
      check_pulses(1, "mid_total");
   endtask

   task automatic test_random();
      logic [15:0] keys;
      int          sel;
      int          k1;
      int          k2;
      k1 = $urandom_range(0, 15);
      for (int f = 0; f < 40; f++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3) begin
            keys = 16'h0000;
         end else if (sel < 8) begin
            if ($urandom_range(0, 3) == 0) k1 = $urandom_range(0, 15);
            keys = 16'h0001 << k1;
         end else begin
            k2 = (k1 + 1 + $urandom_range(0, 14)) % 16;
            keys = (16'h0001 << k1) | (16'h0001 << k2);
         end
         run_frame(keys, "random");
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_ghost_rollover();
      test_reset_mid_debounce();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
